// File: rtl/aes_pkg.sv
// Shared AES state geometry, byte sequencer FSM encoding and byte-select helper.
// No logic of its own; used by the SubBytes byte sequencer and its token pipe.
// Byte 0 is the most significant byte of the 128-bit state.
package aes_pkg;

    localparam int BYTE_W  = 8;
    localparam int NBYTES  = 16;
    localparam int STATE_W = BYTE_W * NBYTES;
    localparam int CNT_W   = 5;   // issue count 0..16
    localparam int IDX_W   = 4;   // byte index 0..15

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // Byte i of the state lives in bits [127-8i -: 8].
    function automatic logic [BYTE_W-1:0] get_byte(
        input logic [STATE_W-1:0] st,
        input logic [IDX_W-1:0]   idx
    );
        return st[STATE_W-1-BYTE_W*int'(idx) -: BYTE_W];
    endfunction

endpackage

// File: rtl/sbox_tok_pipe.sv
// Token shift register tracking which byte each outstanding S-box lookup belongs to.
// Latency: DEPTH edges from in_vld to out_vld.
// No backpressure: shifts every cycle; clr empties it synchronously.
module sbox_tok_pipe
    import aes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

    // Shift one stage per cycle; a clear drops every token in flight.
    always_comb begin
        vld_d = '0;
        idx_d = '0;
        if (!clr) begin
            vld_d[0] = in_vld;
            idx_d[0] = in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                idx_d[i] = idx_q[i-1];
            end
        end
    end

    // Token registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/sub_bytes_seq.sv
// SubBytes sequencer: issues 16 byte lookups to a registered S-box LUT and reassembles the results.
// Latency: out_valid rises 16+LUT_LAT+1 edges after the accept edge.
// Holds out_valid/out_state until out_ready; accepts no new block until back in IDLE.
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LUT_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               flush,
    output logic               sbox_en,
    output logic [BYTE_W-1:0]  sbox_sel,
    input  logic [BYTE_W-1:0]  sbox_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    seq_state_e         state_q, state_d;
    logic [STATE_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sbox_en_q, sbox_en_d;
    logic [BYTE_W-1:0]  sbox_sel_q, sbox_sel_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [STATE_W-1:0] out_state_q, out_state_d;
    logic               busy_q, busy_d;
    logic               cap_last_q, cap_last_d;
    logic               tok_vld;
    logic [IDX_W-1:0]   tok_idx;

    // Token for each request enters alongside it and exits when sbox_data holds its result.
    sbox_tok_pipe #(
        .DEPTH (LUT_LAT + 1)
    ) u_tok_pipe (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr     (flush),
        .in_vld  (sbox_en_d),
        .in_idx  (cnt_d[IDX_W-1:0]),
        .out_vld (tok_vld),
        .out_idx (tok_idx)
    );

    // Next-state, request generation, result capture and flush override.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        cnt_d       = cnt_q;
        sbox_en_d   = 1'b0;
        sbox_sel_d  = sbox_sel_q;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        cap_last_d  = cap_last_q;

        if (tok_vld) begin
            out_state_d[STATE_W-1-BYTE_W*int'(tok_idx) -: BYTE_W] = sbox_data;
            if (tok_idx == LAST_IDX) begin
                cap_last_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    // Byte 0 goes out on the accept edge so the issue burst has no bubble.
                    blk_d      = in_state;
                    cnt_d      = '0;
                    sbox_en_d  = 1'b1;
                    sbox_sel_d = get_byte(in_state, '0);
                    in_ready_d = 1'b0;
                    cap_last_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = DONE_CNT;
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    sbox_en_d  = 1'b1;
                    sbox_sel_d = get_byte(blk_q, cnt_d[IDX_W-1:0]);
                end
            end
            DRAIN: begin
                if (cap_last_q) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops everything in flight but leaves the last result visible on out_state.
        if (flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sbox_en_d   = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_state_d = out_state_q;
            cap_last_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            blk_q       <= '0;
            cnt_q       <= '0;
            sbox_en_q   <= 1'b0;
            sbox_sel_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            busy_q      <= 1'b0;
            cap_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            sbox_en_q   <= sbox_en_d;
            sbox_sel_q  <= sbox_sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            busy_q      <= busy_d;
            cap_last_q  <= cap_last_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sbox_en   = sbox_en_q;
    assign sbox_sel  = sbox_sel_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LUT_LAT 1, 2, 3) share stimulus.
// Each instance has a registered forward S-box model and a monitor that checks latency and results.
// Expected outputs are queued when blocks are issued and popped on each out handshake.
module tb_sub_bytes_seq;

    localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] O1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] V0 = 128'h0;
    localparam logic [127:0] O0 = 128'h63636363636363636363636363636363;
    localparam logic [127:0] V2 = 128'h0123456789abcdeffedcba9876543210;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [127:0]      in_state;
    logic              flush;
    logic              out_ready;
    logic [2:0]        in_ready;
    logic [2:0]        sbox_en;
    logic [2:0]        out_valid;
    logic [2:0]        busy;
    logic [2:0][7:0]   sbox_sel;
    logic [2:0][7:0]   sbox_data;
    logic [2:0][127:0] out_state;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           popped [3] = '{0, 0, 0};
    logic [127:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = g + 1;
        logic [7:0] lut_r [3];

        sub_bytes_seq #(.LUT_LAT(LAT)) u_dut (
            .CLK       (clk),
            .RST_N     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .in_state  (in_state),
            .flush     (flush),
            .sbox_en   (sbox_en[g]),
            .sbox_sel  (sbox_sel[g]),
            .sbox_data (sbox_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );

        // Registered S-box with LAT edges from sampling to result.
        always @(posedge clk) begin
            lut_r[0] <= sbox_en[g] ? SBOX[sbox_sel[g]] : 8'h00;
            lut_r[1] <= lut_r[0];
            lut_r[2] <= lut_r[1];
        end
        assign sbox_data[g] = lut_r[LAT-1];

        initial begin : mon
            int           lat;
            int           en_cnt;
            int           sel_i;
            bit           armed;
            bit           prev_vld;
            logic [127:0] cur_in;
            logic [127:0] held;
            logic [7:0]   want_sel;
            lat = 0; en_cnt = 0; sel_i = 0; armed = 0; prev_vld = 0;
            cur_in = '0; held = '0; want_sel = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    armed    = 0;
                    prev_vld = 0;
                end else begin
                    if (armed) lat++;
                    if (sbox_en[g]) begin
                        if (sel_i < 16) begin
                            want_sel = cur_in[127 - 8*sel_i -: 8];
                            chk(sbox_sel[g] == want_sel, $sformatf("sbox_sel byte%0d lat%0d", sel_i, LAT),
                                128'(sbox_sel[g]), 128'(want_sel));
                        end else begin
                            chk(1'b0, $sformatf("extra sbox_en lat%0d", LAT), 128'(sel_i), 128'(15));
                        end
                        sel_i++;
                        en_cnt++;
                    end
                    if (out_valid[g]) begin
                        if (!prev_vld) begin
                            chk(armed && lat == 17 + LAT, $sformatf("latency lat%0d", LAT), 128'(lat), 128'(17 + LAT));
                            chk(en_cnt == 16, $sformatf("sbox_en cycles lat%0d", LAT), 128'(en_cnt), 128'(16));
                            held = out_state[g];
                        end else begin
                            chk(out_state[g] == held, $sformatf("out_state hold lat%0d", LAT), out_state[g], held);
                        end
                        chk(!in_ready[g] && busy[g], $sformatf("done in_ready/busy lat%0d", LAT),
                            128'({in_ready[g], busy[g]}), 128'(2'b01));
                        if (out_ready) begin
                            if (popped[g] < exp_q.size()) begin
                                chk(out_state[g] == exp_q[popped[g]], $sformatf("out_state lat%0d", LAT),
                                    out_state[g], exp_q[popped[g]]);
                                popped[g]++;
                            end else begin
                                chk(1'b0, $sformatf("unexpected output lat%0d", LAT), out_state[g], 128'(0));
                            end
                            armed = 0;
                        end
                    end
                    prev_vld = out_valid[g];
                    if (in_valid && in_ready[g]) begin
                        armed  = 1;
                        lat    = -1;
                        en_cnt = 0;
                        sel_i  = 0;
                        cur_in = in_state;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] v, input bit expect_out, input logic [127:0] o);
        int t;
        t = 0;
        while (in_ready != 3'b111 && t < 100) begin
            tick();
            t++;
        end
        chk(in_ready == 3'b111, "in_ready before send", 128'(in_ready), 128'(3'b111));
        if (expect_out) exp_q.push_back(o);
        in_valid = 1'b1;
        in_state = v;
        tick();
        in_valid = 1'b0;
        in_state = '1;
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while ((popped[0] != exp_q.size() || popped[1] != exp_q.size() || popped[2] != exp_q.size()) && t < 200) begin
            tick();
            t++;
        end
        chk(t < 200, "drain timeout", 128'(t), 128'(200));
    endtask

    task automatic chk_all_zero(input string name);
        chk({in_ready, sbox_en, out_valid, busy} == 12'h0, {name, " ctl"},
            128'({in_ready, sbox_en, out_valid, busy}), 128'(0));
        chk(sbox_sel == '0, {name, " sbox_sel"}, 128'(sbox_sel), 128'(0));
        for (int i = 0; i < 3; i++) chk(out_state[i] == '0, {name, " out_state"}, out_state[i], 128'(0));
    endtask

    initial begin
        int t;
        rst_n = 1'b1; in_valid = 1'b0; in_state = '0; flush = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) tick();
        @(negedge clk) rst_n = 1'b1;
        chk(in_ready == 3'b000, "in_ready before first edge", 128'(in_ready), 128'(0));
        tick();
        chk(in_ready == 3'b111, "in_ready after first edge", 128'(in_ready), 128'(3'b111));

        // Basic vector and all-zero state.
        send(V1, 1'b1, O1);
        wait_drained();
        send(V0, 1'b1, O0);
        wait_drained();

        // Downstream stall for 10 cycles after out_valid.
        out_ready = 1'b0;
        send(V1, 1'b1, O1);
        t = 0;
        while (!out_valid[2] && t < 100) begin
            tick();
            t++;
        end
        repeat (10) tick();
        chk(out_valid == 3'b111, "valid held under stall", 128'(out_valid), 128'(3'b111));
        out_ready = 1'b1;
        tick();
        chk(out_valid == 3'b000, "valid drops after handshake", 128'(out_valid), 128'(0));
        wait_drained();

        // Flush while byte 7 is on sbox_sel; that block must never appear.
        send(V2, 1'b0, '0);
        repeat (7) tick();
        chk(sbox_sel[0] == 8'hef, "sbox_sel at flush", 128'(sbox_sel[0]), 128'(8'hef));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk({sbox_en, out_valid, busy} == 9'h0, "after flush ctl", 128'({sbox_en, out_valid, busy}), 128'(0));
        chk(in_ready == 3'b111, "in_ready after flush", 128'(in_ready), 128'(3'b111));
        send(V1, 1'b1, O1);
        wait_drained();

        // Asynchronous reset while draining.
        send(V1, 1'b0, '0);
        repeat (16) tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset mid drain");
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk(in_ready == 3'b111, "in_ready after re-reset", 128'(in_ready), 128'(3'b111));
        send(V1, 1'b1, O1);
        wait_drained();
        repeat (5) tick();

        for (int i = 0; i < 3; i++)
            chk(popped[i] == exp_q.size(), "output count", 128'(popped[i]), 128'(exp_q.size()));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
